// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit_if                                                         |
// | Request, data-memory and writeback bundle for load_store_unit.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface load_store_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_is_store;
  logic [7:0] base_addr;
  logic [7:0] offset;
  logic [7:0] store_data;
  logic [2:0] dest_reg;

  logic       enable_write;
  logic       enable_read;
  logic [7:0] ram_addr;
  logic [7:0] write_data;
  logic [7:0] read_data;

  logic       wb_valid;
  logic       wb_is_load;
  logic [7:0] wb_data;
  logic [2:0] wb_reg;
  logic       wb_wrap;

  modport slave (
    input  req_valid, req_is_store, base_addr, offset, store_data, dest_reg, read_data,
    output req_ready, enable_write, enable_read, ram_addr, write_data,
           wb_valid, wb_is_load, wb_data, wb_reg, wb_wrap
  );

  modport master (
    output req_valid, req_is_store, base_addr, offset, store_data, dest_reg, read_data,
    input  req_ready, enable_write, enable_read, ram_addr, write_data,
           wb_valid, wb_is_load, wb_data, wb_reg, wb_wrap
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit                                                            |
// | Three-state (IDLE/ACCESS/DONE) load/store sequencer for an 8-bit memory.   |
// | Optional LSU_STORE_FWD_EN: last-store buffer forwarding to matching loads. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module load_store_unit (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  lsu_bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic       is_store_q;
  logic       wrap_q;
  logic [2:0] dest_q;
  logic [7:0] ram_addr_q;
  logic [7:0] write_data_q;
  logic [7:0] wb_data_q;
  logic [2:0] wb_reg_q;
  logic       wb_is_load_q;
  logic       wb_wrap_q;

  logic [8:0] w_sum;
  logic       w_hs;
  logic       w_fwd_hit;
  logic [7:0] w_fwd_data;
  logic       w_req_ready;
  logic       w_en_wr;
  logic       w_en_rd;
  logic       w_wb_valid;

  assign w_sum = {1'b0, lsu_bus.base_addr} + {1'b0, lsu_bus.offset};
  assign w_hs  = lsu_bus.req_valid && (state_q == S_IDLE);

`ifdef LSU_STORE_FWD_EN
  logic       sb_valid_q;
  logic [7:0] sb_addr_q;
  logic [7:0] sb_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid_q <= 1'b0;
      sb_addr_q  <= 8'h00;
      sb_data_q  <= 8'h00;
    end else if ((state_q == S_ACCESS) && is_store_q) begin
      sb_valid_q <= 1'b1;
      sb_addr_q  <= ram_addr_q;
      sb_data_q  <= write_data_q;
    end
  end

  assign w_fwd_hit  = !lsu_bus.req_is_store && sb_valid_q && (sb_addr_q == w_sum[7:0]);
  assign w_fwd_data = sb_data_q;
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_hs) state_d = w_fwd_hit ? S_DONE : S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // req_ready is masked by reset so it reads 0 for the whole reset pulse.
  always_comb begin
    w_req_ready = (state_q == S_IDLE) && !reset;
    w_en_wr     = (state_q == S_ACCESS) && is_store_q;
    w_en_rd     = (state_q == S_ACCESS) && !is_store_q;
    w_wb_valid  = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_q   <= 1'b0;
      wrap_q       <= 1'b0;
      dest_q       <= 3'd0;
      ram_addr_q   <= 8'h00;
      write_data_q <= 8'h00;
      wb_data_q    <= 8'h00;
      wb_reg_q     <= 3'd0;
      wb_is_load_q <= 1'b0;
      wb_wrap_q    <= 1'b0;
    end else if (w_hs) begin
      is_store_q <= lsu_bus.req_is_store;
      wrap_q     <= w_sum[8];
      dest_q     <= lsu_bus.dest_reg;
      if (w_fwd_hit) begin
        // Forwarded load completes straight from the buffer; memory outputs keep their old values.
        wb_data_q    <= w_fwd_data;
        wb_reg_q     <= lsu_bus.dest_reg;
        wb_is_load_q <= 1'b1;
        wb_wrap_q    <= w_sum[8];
      end else begin
        ram_addr_q <= w_sum[7:0];
        if (lsu_bus.req_is_store) begin
          write_data_q <= lsu_bus.store_data;
        end
      end
    end else if (state_q == S_ACCESS) begin
      wb_is_load_q <= !is_store_q;
      wb_data_q    <= is_store_q ? write_data_q : lsu_bus.read_data;
      wb_reg_q     <= is_store_q ? 3'd0 : dest_q;
      wb_wrap_q    <= wrap_q;
    end
  end

  assign lsu_bus.req_ready    = w_req_ready;
  assign lsu_bus.enable_write = w_en_wr;
  assign lsu_bus.enable_read  = w_en_rd;
  assign lsu_bus.ram_addr     = ram_addr_q;
  assign lsu_bus.write_data   = write_data_q;
  assign lsu_bus.wb_valid     = w_wb_valid;
  assign lsu_bus.wb_is_load   = wb_is_load_q;
  assign lsu_bus.wb_data      = wb_data_q;
  assign lsu_bus.wb_reg       = wb_reg_q;
  assign lsu_bus.wb_wrap      = wb_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit                                                         |
// | Randomized scoreboard bench for load_store_unit with a memory model.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit         st;
    logic [7:0] addr;
    logic       wrap;
    logic [7:0] data;
    logic [2:0] rg;
    int         hs;
    bit         fwd;
    bit         acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if lsu();

  load_store_unit dut (
    .clk     (clk),
    .reset   (reset),
    .lsu_bus (lsu)
  );

  // Environment memory, driven purely by the DUT's strobes.
  logic [7:0] env_mem [256];
  assign lsu.read_data = lsu.enable_read ? env_mem[lsu.ram_addr] : 8'h5A;
  always @(posedge clk) if (lsu.enable_write) env_mem[lsu.ram_addr] = lsu.write_data;

  // Reference model state: architectural memory and the last store seen since reset.
  logic [7:0] mem_model [256];
  bit         st_valid = 1'b0;
  logic [7:0] st_addr = 8'h00;
  exp_t       exp_q[$];

  bit         have_last = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [2:0] last_rg = 3'd0;
  logic       last_ld = 1'b0;
  logic       last_wrap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_push(input bit st, input logic [7:0] b, input logic [7:0] o,
                                     input logic [7:0] d, input logic [2:0] dr, input int hs);
    int   sum;
    exp_t e;
    sum    = int'(b) + int'(o);
    e.st   = st;
    e.addr = 8'(sum % 256);
    e.wrap = (sum > 255);
    e.hs   = hs;
    e.acc  = 1'b0;
    if (st) begin
      mem_model[e.addr] = d;
      e.data   = d;
      e.rg     = 3'd0;
      e.fwd    = 1'b0;
      st_valid = 1'b1;
      st_addr  = e.addr;
    end else begin
      e.fwd  = FWD && st_valid && (st_addr == e.addr);
      e.data = mem_model[e.addr];
      e.rg   = dr;
    end
    exp_q.push_back(e);
  endfunction

  // Returns right after the handshake edge; req_valid is left high.
  task automatic issue(input bit st, input logic [7:0] b, input logic [7:0] o,
                       input logic [7:0] d, input logic [2:0] dr);
    int g = 0;
    @(negedge clk);
    lsu.req_valid    = 1'b1;
    lsu.req_is_store = st;
    lsu.base_addr    = b;
    lsu.offset       = o;
    lsu.store_data   = d;
    lsu.dest_reg     = dr;
    while (!lsu.req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!lsu.req_ready) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      lsu.req_valid = 1'b0;
      return;
    end
    model_push(st, b, o, d, dr, cyc + 1);
    @(posedge clk);
  endtask

  task automatic wait_wb(input string name);
    int g = 0;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    while (!lsu.wb_valid && g < 8) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_wb_valid"}, 32'(lsu.wb_valid), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    while (exp_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: checks every memory access and completion against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (lsu.enable_write || lsu.enable_read) begin
        chk("strobe_exclusive", 32'(lsu.enable_write & lsu.enable_read), 32'd0);
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", {lsu.enable_write, lsu.enable_read}, 32'd0);
        end else begin
          e = exp_q[0];
          chk("acc_we", 32'(lsu.enable_write), 32'(e.st));
          chk("acc_re", 32'(lsu.enable_read), 32'(!e.st && !e.fwd));
          chk("acc_addr", 32'(lsu.ram_addr), 32'(e.addr));
          if (e.st) chk("acc_wdata", 32'(lsu.write_data), 32'(e.data));
          chk("acc_cycle", 32'(cyc), 32'(e.hs));
          chk("acc_once", 32'(e.acc), 32'd0);
          e.acc = 1'b1;
          exp_q[0] = e;
        end
      end
      if (lsu.wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(lsu.wb_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_is_load", 32'(lsu.wb_is_load), 32'(!e.st));
          chk("wb_data", 32'(lsu.wb_data), 32'(e.data));
          chk("wb_reg", 32'(lsu.wb_reg), 32'(e.rg));
          chk("wb_wrap", 32'(lsu.wb_wrap), 32'(e.wrap));
          chk("wb_cycle", 32'(cyc), 32'(e.fwd ? e.hs : e.hs + 1));
          if (!e.fwd) chk("wb_had_access", 32'(e.acc), 32'd1);
          have_last = 1'b1;
          last_data = e.data;
          last_rg   = e.rg;
          last_ld   = !e.st;
          last_wrap = e.wrap;
        end
      end else if (have_last) begin
        chk("wb_hold", {lsu.wb_is_load, lsu.wb_wrap, lsu.wb_reg, lsu.wb_data},
            {last_ld, last_wrap, last_rg, last_data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         st;
    logic [7:0] b, o, d, old, stim_last, a;
    logic [2:0] dr;
    bit         have_st;
    int         hs_cnt;

    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      env_mem[i]   = a;
      mem_model[i] = a;
    end
    reset            = 1'b1;
    lsu.req_valid    = 1'b0;
    lsu.req_is_store = 1'b0;
    lsu.base_addr    = 8'h00;
    lsu.offset       = 8'h00;
    lsu.store_data   = 8'h00;
    lsu.dest_reg     = 3'd0;

    @(negedge clk);
    chk("rst_ready", 32'(lsu.req_ready), 32'd0);
    chk("rst_strobes", {lsu.enable_write, lsu.enable_read, lsu.wb_valid}, 32'd0);
    chk("rst_regs", {lsu.ram_addr, lsu.write_data, lsu.wb_data}, 32'd0);
    chk("rst_wb_misc", {lsu.wb_reg, lsu.wb_is_load, lsu.wb_wrap}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(lsu.req_ready), 32'd1);
    have_last = 1'b1;

    // Directed: store 0x10+0x05 <- 0xA5
    issue(1'b1, 8'h10, 8'h05, 8'hA5, 3'd0);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    chk("dir_st_we", 32'(lsu.enable_write), 32'd1);
    chk("dir_st_addr", 32'(lsu.ram_addr), 32'h15);
    chk("dir_st_wdata", 32'(lsu.write_data), 32'hA5);
    wait_wb("dir_st");
    chk("dir_st_wrap", 32'(lsu.wb_wrap), 32'd0);

    // Directed: load back from 0x15 into r3
    issue(1'b0, 8'h10, 8'h05, 8'h00, 3'd3);
    wait_wb("dir_ld");
    chk("dir_ld_data", 32'(lsu.wb_data), 32'hA5);
    chk("dir_ld_reg", 32'(lsu.wb_reg), 32'd3);
    chk("dir_ld_isload", 32'(lsu.wb_is_load), 32'd1);

    // Directed: wrapping load 0xF0+0x20
    issue(1'b0, 8'hF0, 8'h20, 8'h00, 3'd5);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    chk("dir_wrap_re", 32'(lsu.enable_read), 32'd1);
    chk("dir_wrap_addr", 32'(lsu.ram_addr), 32'h10);
    wait_wb("dir_wrap");
    chk("dir_wrap_flag", 32'(lsu.wb_wrap), 32'd1);

    // Directed: store 0x33 to 0x40, reload 0x40 and 0x41
    issue(1'b1, 8'h40, 8'h00, 8'h33, 3'd0);
    wait_wb("dir_fst");
    issue(1'b0, 8'h30, 8'h10, 8'h00, 3'd1);
    wait_wb("dir_fld");
    chk("dir_fld_data", 32'(lsu.wb_data), 32'h33);
    issue(1'b0, 8'h40, 8'h01, 8'h00, 3'd2);
    drain();

    // Randomized traffic with occasional idle gaps and store->load address reuse
    have_st   = 1'b0;
    stim_last = 8'h00;
    for (int n = 0; n < 250; n++) begin
      st = ($urandom_range(0, 2) == 0);
      b  = 8'($urandom);
      o  = 8'($urandom);
      d  = 8'($urandom);
      dr = 3'($urandom);
      if (!st && have_st && $urandom_range(0, 2) == 0) o = stim_last - b;
      if (st) begin
        stim_last = b + o;
        have_st   = 1'b1;
      end
      issue(st, b, o, d, dr);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        lsu.req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    // Throughput: request held for 10 cycles
    @(negedge clk);
    lsu.req_valid    = 1'b1;
    lsu.req_is_store = 1'b1;
    lsu.base_addr    = 8'h21;
    lsu.offset       = 8'h42;
    lsu.store_data   = 8'h7E;
    lsu.dest_reg     = 3'd6;
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (lsu.req_ready) begin
        hs_cnt++;
        model_push(1'b1, 8'h21, 8'h42, 8'h7E, 3'd6, cyc + 1);
      end
      @(negedge clk);
    end
    lsu.req_valid = 1'b0;
    chk("throughput_hs", 32'(hs_cnt), 32'd4);
    drain();

    // Reset during a store's ACCESS cycle
    old = mem_model[8'h99];
    issue(1'b1, 8'h90, 8'h09, 8'hC3, 3'd0);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    chk("rst_mid_pre_we", 32'(lsu.enable_write), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_we_async", 32'(lsu.enable_write), 32'd0);
    chk("rst_mid_ready", 32'(lsu.req_ready), 32'd0);
    chk("rst_mid_wbv", 32'(lsu.wb_valid), 32'd0);
    chk("rst_mid_regs", {lsu.ram_addr, lsu.write_data, lsu.wb_data}, 32'd0);
    chk("rst_mid_wb_misc", {lsu.wb_reg, lsu.wb_is_load, lsu.wb_wrap}, 32'd0);
    mem_model[8'h99] = old;
    st_valid  = 1'b0;
    exp_q.delete();
    last_data = 8'h00;
    last_rg   = 3'd0;
    last_ld   = 1'b0;
    last_wrap = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready_after", 32'(lsu.req_ready), 32'd1);

    // Post-reset: the aborted store must not be visible
    issue(1'b0, 8'h90, 8'h09, 8'h00, 3'd4);
    issue(1'b0, 8'h15, 8'h00, 8'h00, 3'd7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
